// File: rtl/seg7_capture.sv
// Reverse 7-segment decoder: synchronizes a multiplexed segment bus, waits for a stable pattern
// and emits {digit, value} over valid/ready. Optional error counter: define SEG7_ERRCNT_EN.
module seg7_capture #(
    parameter int NDIG       = 4,
    parameter int STABLE_CYC = 8,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     a,
    input  logic                     b,
    input  logic                     c,
    input  logic                     d,
    input  logic                     e,
    input  logic                     f,
    input  logic                     g,
    input  logic [NDIG-1:0]          dig_en,
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic [$clog2(NDIG)-1:0]  out_dig,
    output logic [3:0]               out_val,
    output logic                     out_err,
`ifdef SEG7_ERRCNT_EN
    output logic [7:0]               err_cnt,
    input  logic                     err_clr,
`endif
    output logic [4*NDIG-1:0]        shadow
);

    localparam int IW = $clog2(NDIG);
    localparam int SW = 7 + NDIG;
    localparam logic [7:0] CNT_MAX = 8'(STABLE_CYC - 1);

    typedef enum logic [1:0] {IDLE, SETTLE, EMIT, WAIT_CHG} state_t;

    // Returns {err, value}; anything outside the 16 glyphs is flagged with value 0.
    function automatic logic [4:0] decode_glyph(input logic [6:0] p);
        case (p)
            7'h7E:   decode_glyph = {1'b0, 4'h0};
            7'h30:   decode_glyph = {1'b0, 4'h1};
            7'h6D:   decode_glyph = {1'b0, 4'h2};
            7'h79:   decode_glyph = {1'b0, 4'h3};
            7'h33:   decode_glyph = {1'b0, 4'h4};
            7'h5B:   decode_glyph = {1'b0, 4'h5};
            7'h5F:   decode_glyph = {1'b0, 4'h6};
            7'h70:   decode_glyph = {1'b0, 4'h7};
            7'h7F:   decode_glyph = {1'b0, 4'h8};
            7'h7B:   decode_glyph = {1'b0, 4'h9};
            7'h77:   decode_glyph = {1'b0, 4'hA};
            7'h1F:   decode_glyph = {1'b0, 4'hB};
            7'h4E:   decode_glyph = {1'b0, 4'hC};
            7'h3D:   decode_glyph = {1'b0, 4'hD};
            7'h4F:   decode_glyph = {1'b0, 4'hE};
            7'h47:   decode_glyph = {1'b0, 4'hF};
            default: decode_glyph = {1'b1, 4'h0};
        endcase
    endfunction

    function automatic logic is_onehot(input logic [NDIG-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < NDIG; i++) begin
            if (v[i]) n = n + 1;
        end
        return (n == 32'd1);
    endfunction

    function automatic logic [IW-1:0] onehot_index(input logic [NDIG-1:0] v);
        logic [IW-1:0] idx;
        idx = '0;
        for (int i = 0; i < NDIG; i++) begin
            if (v[i]) idx = IW'(i);
        end
        return idx;
    endfunction

    logic [6:0]      seg_meta_r, seg_sync_r;
    logic [NDIG-1:0] dig_meta_r, dig_sync_r;
    logic [6:0]      p_s;
    logic [SW-1:0]   cur_s, prev_r, cap_r;
    logic [7:0]      stab_cnt_r;
    logic            changed_s, onehot_s;
    logic [IW-1:0]   idx_s;
    logic [4:0]      dec_s;
    state_t          state_r;

    // Derive the lit pattern and the change/one-hot views of the synced bus.
    always_comb begin
        if (ACTIVE_LOW != 0) begin
            p_s = ~seg_sync_r;
        end else begin
            p_s = seg_sync_r;
        end
        cur_s     = {p_s, dig_sync_r};
        changed_s = (cur_s != prev_r);
        onehot_s  = is_onehot(dig_sync_r);
        idx_s     = onehot_index(dig_sync_r);
        dec_s     = decode_glyph(p_s);
    end

    // Two-flop synchronizer for the asynchronous segment and digit lines.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_meta_r <= 7'h00;
            seg_sync_r <= 7'h00;
            dig_meta_r <= '0;
            dig_sync_r <= '0;
        end else begin
            seg_meta_r <= {a, b, c, d, e, f, g};
            seg_sync_r <= seg_meta_r;
            dig_meta_r <= dig_en;
            dig_sync_r <= dig_meta_r;
        end
    end

    // Stability counter: restarts on any change of the synced sample, saturates at the threshold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_r     <= '0;
            stab_cnt_r <= 8'd0;
        end else begin
            prev_r <= cur_s;
            if (changed_s) begin
                stab_cnt_r <= 8'd0;
            end else if (stab_cnt_r != CNT_MAX) begin
                stab_cnt_r <= stab_cnt_r + 8'd1;
            end else begin
                stab_cnt_r <= stab_cnt_r;
            end
        end
    end

    // Capture FSM with registered output word and per-digit shadow registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= IDLE;
            cap_r     <= '0;
            out_valid <= 1'b0;
            out_dig   <= '0;
            out_val   <= 4'h0;
            out_err   <= 1'b0;
            shadow    <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (onehot_s) state_r <= SETTLE;
                    else          state_r <= IDLE;
                end
                SETTLE: begin
                    if (!onehot_s) begin
                        state_r <= IDLE;
                    end else if (changed_s) begin
                        state_r <= SETTLE;
                    end else if (stab_cnt_r == CNT_MAX) begin
                        cap_r <= cur_s;
                        if (p_s == 7'h00) begin
                            state_r <= WAIT_CHG;
                        end else begin
                            out_valid <= 1'b1;
                            out_dig   <= idx_s;
                            out_val   <= dec_s[3:0];
                            out_err   <= dec_s[4];
                            state_r   <= EMIT;
                        end
                    end else begin
                        state_r <= SETTLE;
                    end
                end
                EMIT: begin
                    // The word in flight is frozen; the bus is ignored until the handshake.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state_r   <= WAIT_CHG;
                        for (int k = 0; k < NDIG; k++) begin
                            if (!out_err && (out_dig == IW'(k))) shadow[4*k +: 4] <= out_val;
                        end
                    end else begin
                        state_r <= EMIT;
                    end
                end
                WAIT_CHG: begin
                    if (cur_s != cap_r) state_r <= onehot_s ? SETTLE : IDLE;
                    else                state_r <= WAIT_CHG;
                end
                default: state_r <= IDLE;
            endcase
        end
    end

`ifdef SEG7_ERRCNT_EN
    // Saturating count of accepted error words; clear has priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt <= 8'd0;
        end else if (err_clr) begin
            err_cnt <= 8'd0;
        end else if (out_valid && out_ready && out_err && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'd1;
        end else begin
            err_cnt <= err_cnt;
        end
    end
`endif

endmodule
